// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner with per-sweep debounce, feeding a digital lock.
// Optional macro KEYPAD_GHOST_REJECT_EN blanks KEYS/STAR/HASH on multi-key states.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] ROW,
  output logic [2:0] COL,
  output logic [9:0] KEYS,
  output logic       STAR,
  output logic       HASH,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE,
  output logic       MULTI
);

  typedef enum logic [1:0] {
    SLOT_C0 = 2'd0,
    SLOT_C1 = 2'd1,
    SLOT_C2 = 2'd2
  } slot_e;

  localparam logic [15:0] LAST_CYC     = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  ACCEPT_MATCH = 4'(DEBOUNCE_SCANS - 1);

  // Raw snapshots are indexed col*4 + row; this reorders them into
  // {#, *, 9..0} so the key-facing logic can work in digit order.
  function automatic logic [11:0] to_logical(input logic [11:0] s);
    return {s[11], s[3], s[10], s[6], s[2], s[9], s[5], s[1], s[8], s[4], s[0], s[7]};
  endfunction

  function automatic logic [3:0] count_ones(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [3:0] digit_bcd(input logic [9:0] d);
    logic [3:0] code;
    code = '0;
    for (int i = 9; i >= 0; i--) if (d[i]) code = 4'(i);
    return code;
  endfunction

  slot_e       slot_q, slot_d;
  logic [15:0] cyc_q, cyc_d;
  logic [3:0]  row_meta_q, row_sync_q;
  logic [11:0] raw_q, raw_d;
  logic [11:0] prev_q, prev_d;
  logic [11:0] acc_q, acc_d;
  logic [3:0]  match_q, match_d;
  logic        vld_pend_q, vld_pend_d;

  logic [9:0]  keys_q, keys_d;
  logic        star_q, star_d;
  logic        hash_q, hash_d;
  logic        multi_q, multi_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_code_q, key_code_d;

  logic        sweep_end;
  logic [11:0] snap_logical;
  logic [11:0] acc_logical;
  logic [11:0] shown;

  // Scan and debounce datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    slot_d       = slot_q;
    cyc_d        = cyc_q + 16'd1;
    raw_d        = raw_q;
    prev_d       = prev_q;
    match_d      = match_q;
    acc_d        = acc_q;
    vld_pend_d   = 1'b0;
    sweep_end    = 1'b0;
    snap_logical = '0;

    if (cyc_q == LAST_CYC) begin
      cyc_d = '0;
      unique case (slot_q)
        SLOT_C0: begin
          raw_d[3:0] = ~row_sync_q;
          slot_d     = SLOT_C1;
        end
        SLOT_C1: begin
          raw_d[7:4] = ~row_sync_q;
          slot_d     = SLOT_C2;
        end
        SLOT_C2: begin
          raw_d[11:8] = ~row_sync_q;
          slot_d      = SLOT_C0;
          sweep_end   = 1'b1;
        end
        default: slot_d = SLOT_C0;
      endcase
    end

    if (sweep_end) begin
      snap_logical = to_logical(raw_d);
      prev_d       = raw_d;
      if (raw_d == prev_q) match_d = (match_q == 4'd15) ? 4'd15 : match_q + 4'd1;
      else                 match_d = '0;

      if ((match_d == ACCEPT_MATCH) && (raw_d != acc_q)) begin
        acc_d = raw_d;
        // Strobe only for a fresh single-digit press out of an all-released state.
        vld_pend_d = (acc_q == '0) && (count_ones(raw_d) == 4'd1)
                     && (snap_logical[11:10] == 2'b00);
      end
    end
  end

  // Output stage: derived from the accepted state, one cycle behind it.
  always_comb begin
    acc_logical = to_logical(acc_q);
    multi_d     = (count_ones(acc_q) >= 4'd2);
`ifdef KEYPAD_GHOST_REJECT_EN
    shown       = multi_d ? '0 : acc_logical;
`else
    // Isolate the lowest set bit: digits 0..9 first, then *, then #.
    shown       = acc_logical & (~acc_logical + 12'd1);
`endif
    keys_d      = shown[9:0];
    star_d      = shown[10];
    hash_d      = shown[11];
    key_valid_d = vld_pend_q;
    key_code_d  = vld_pend_q ? digit_bcd(acc_logical[9:0]) : key_code_q;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: snapshot registers are reset too, so the first sweep compares against a known empty state.
      slot_q      <= SLOT_C0;
      cyc_q       <= '0;
      row_meta_q  <= '0;
      row_sync_q  <= '0;
      raw_q       <= '0;
      prev_q      <= '0;
      acc_q       <= '0;
      match_q     <= '0;
      vld_pend_q  <= 1'b0;
      keys_q      <= '0;
      star_q      <= 1'b0;
      hash_q      <= 1'b0;
      multi_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      slot_q      <= slot_d;
      cyc_q       <= cyc_d;
      row_meta_q  <= ROW;
      row_sync_q  <= row_meta_q;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      match_q     <= match_d;
      vld_pend_q  <= vld_pend_d;
      keys_q      <= keys_d;
      star_q      <= star_d;
      hash_q      <= hash_d;
      multi_q     <= multi_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  always_comb begin
    unique case (slot_q)
      SLOT_C1: COL = 3'b101;
      SLOT_C2: COL = 3'b011;
      default: COL = 3'b110;
    endcase
  end

  assign KEYS      = keys_q;
  assign STAR      = star_q;
  assign HASH      = hash_q;
  assign MULTI     = multi_q;
  assign KEY_VALID = key_valid_q;
  assign KEY_CODE  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model plus a
// sweep-level reference model of debounce, acceptance and key reporting.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;
  localparam int SWEEP    = 3 * SCAN_DIV;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] ROW;
  logic [2:0] COL;
  logic [9:0] KEYS;
  logic       STAR, HASH, KEY_VALID, MULTI;
  logic [3:0] KEY_CODE;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .CLK(CLK), .RESET(RESET), .ROW(ROW), .COL(COL), .KEYS(KEYS), .STAR(STAR),
    .HASH(HASH), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE), .MULTI(MULTI)
  );

  always #5 CLK = ~CLK;

  // Pressed keys by id: 0..9 digits, 10 = *, 11 = #.
  logic [11:0] pressed;

  function automatic int key_row(input int id);
    if (id >= 1 && id <= 9) return (id - 1) / 3;
    return 3;
  endfunction

  function automatic int key_col(input int id);
    if (id >= 1 && id <= 9) return (id - 1) % 3;
    if (id == 0)  return 1;
    if (id == 10) return 0;
    return 2;
  endfunction

  // Passive matrix: a row is pulled low when a pressed key joins it to a driven column.
  always_comb begin
    ROW = 4'hF;
    for (int id = 0; id < 12; id++)
      if (pressed[id] && COL[key_col(id)] == 1'b0) ROW[key_row(id)] = 1'b0;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [11:0] m_acc, m_last;
  int          m_run;
  logic        m_valid_due;
  logic [3:0]  m_code;

  task automatic model_reset();
    m_acc = '0; m_last = '0; m_run = 1; m_valid_due = 1'b0; m_code = '0;
  endtask

  // A new key state is taken once DS consecutive sweeps agree on it.
  task automatic model_sweep(input logic [11:0] set);
    if (set == m_last) m_run = (m_run < 16) ? m_run + 1 : 16;
    else               m_run = 1;
    m_last      = set;
    m_valid_due = 1'b0;
    if (m_run == DS && set != m_acc) begin
      if (m_acc == 0 && $countones(set) == 1 && set[11:10] == 2'b00) begin
        m_valid_due = 1'b1;
        for (int id = 0; id < 10; id++) if (set[id]) m_code = 4'(id);
      end
      m_acc = set;
    end
  endtask

  task automatic check_outputs();
    logic [11:0] shown;
    logic        multi;
    multi = ($countones(m_acc) >= 2);
`ifdef KEYPAD_GHOST_REJECT_EN
    shown = multi ? 12'h000 : m_acc;
`else
    shown = '0;
    for (int id = 11; id >= 0; id--) if (m_acc[id]) shown = 12'(1) << id;
`endif
    check("keys", 32'(KEYS), 32'(shown[9:0]));
    check("star", 32'(STAR), 32'(shown[10]));
    check("hash", 32'(HASH), 32'(shown[11]));
    check("multi", 32'(MULTI), 32'(multi));
    check("key_code", 32'(KEY_CODE), 32'(m_code));
  endtask

  // Called at a negedge just before a sweep starts; returns at the negedge after its last edge.
  task automatic run_sweep(input logic [11:0] set);
    logic [2:0] exp_col;
    pressed = set;
    for (int c = 0; c < SWEEP; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      exp_col = 3'b111 ^ (3'b001 << (((c + 1) / SCAN_DIV) % 3));
      check("col", 32'(COL), 32'(exp_col));
      if (c == 0) check_outputs();
      check("key_valid", 32'(KEY_VALID), (c == 0) ? 32'(m_valid_due) : 32'd0);
    end
    model_sweep(set);
  endtask

  task automatic apply_reset(input int n);
    RESET = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("rst_col", 32'(COL), 32'h6);
      check("rst_outs", {16'h0, KEYS, STAR, HASH, KEY_VALID, MULTI, KEY_CODE}, 32'd0);
    end
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [11:0] set;
    int          hold;
    RESET   = 1'b1;
    pressed = '0;
    model_reset();
    @(negedge CLK);
    apply_reset(3);

    // Hold 5 from reset release: one strobe, no repeat while held.
    for (int i = 0; i < 7; i++) run_sweep(12'h020);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // Key 2 bouncing every sweep never gets accepted.
    for (int i = 0; i < 10; i++) run_sweep((i % 2 == 0) ? 12'h004 : 12'h000);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // 1 and 2 together.
    for (int i = 0; i < 5; i++) run_sweep(12'h006);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // # press and release.
    for (int i = 0; i < 5; i++) run_sweep(12'h800);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // Digit-to-digit change without release gives no strobe.
    for (int i = 0; i < 4; i++) run_sweep(12'h008);
    for (int i = 0; i < 4; i++) run_sweep(12'h010);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // Hold 9, then reset mid-sweep; it is re-accepted with one strobe.
    for (int i = 0; i < 4; i++) run_sweep(12'h200);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("kv_mid", 32'(KEY_VALID), 32'd0);
    end
    apply_reset(2);
    for (int i = 0; i < 5; i++) run_sweep(12'h200);
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    // Random key states held for random numbers of sweeps.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0:       set = '0;
        1, 2:    set = 12'(1) << $urandom_range(0, 11);
        default: set = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      endcase
      hold = $urandom_range(1, 5);
      for (int i = 0; i < hold; i++) run_sweep(set);
    end
    for (int i = 0; i < 4; i++) run_sweep(12'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: CLK cycles each column is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive identical full sweeps needed to accept a new key state; legal range 2..15.
REQ-003 Port CLK, input, 1: system clock; all logic is on the rising edge.
REQ-004 Port RESET, input, 1: reset, synchronous, active-high.
REQ-005 Port ROW, input, 4: matrix rows, active-low, with external pull-ups. Row0 = 1 2 3, row1 = 4 5 6, row2 = 7 8 9, row3 = * 0 #.
REQ-006 Port COL, output, 3: matrix column drive, one-hot active-low. Col0 = 1 4 7 *, col1 = 2 5 8 0, col2 = 3 6 9 #.
REQ-007 Port KEYS, output, 10: debounced level per digit; KEYS[n] high while digit n is held; KEYS[n] drives lock input In.
REQ-008 Port STAR, output, 1: debounced level of the * key; the lock's CLOSE input.
REQ-009 Port HASH, output, 1: debounced level of the # key; the lock's OPEN input.
REQ-010 Port KEY_VALID, output, 1: one-cycle strobe on each accepted new digit press.
REQ-011 Port KEY_CODE, output, 4: BCD of the last accepted digit; held between strobes.
REQ-012 Port MULTI, output, 1: accepted state has more than one key pressed.

Function
REQ-013 ROW shall pass through a 2-flop synchronizer before any use.
REQ-014 A column counter shall drive col0, col1, col2 in turn, then wrap to col0, each for exactly SCAN_DIV cycles; one sweep = 3*SCAN_DIV cycles.
REQ-015 On the last cycle of each column slot, the synchronized inverted ROW shall be captured into that column's 4 bits of a 12-bit raw snapshot.
REQ-016 On col2's capture cycle (sweep end), the completed snapshot shall be compared with the previous sweep's snapshot.
  - Equal: a match counter increments, saturating at 15.
  - Different: the match counter clears to 0.
REQ-017 When the match counter reaches DEBOUNCE_SCANS-1 and the snapshot differs from the accepted state, the accepted state shall take the snapshot at that sweep end.
REQ-018 KEYS, STAR, HASH and MULTI shall update on the cycle after the accepted state changes, giving latency 1 from acceptance.
REQ-019 MULTI = 1 when the accepted state has two or more bits set; otherwise 0.
REQ-020 KEY_VALID shall pulse for exactly 1 cycle, with KEY_CODE updated on the same cycle, when the accepted state changes from no key pressed to exactly one digit.
  - No pulse for *, #, multi-key states, releases, or digit-to-digit changes without an intervening all-released state.
REQ-021 A bounce shorter than DEBOUNCE_SCANS sweeps shall leave all outputs unchanged.
REQ-022 Holding a key indefinitely shall produce exactly one KEY_VALID.

Reset
REQ-023 While RESET = 1, outputs and state shall be:
  - COL = 3'b110 (col0 driven); column, cycle and match counters = 0.
  - Synchronizer flops, raw snapshot, previous snapshot and accepted state = 0.
  - KEYS = 0, STAR = 0, HASH = 0, KEY_VALID = 0, KEY_CODE = 0, MULTI = 0.
REQ-024 Reset asserted mid-sweep or during a held key shall abort the sweep. After release, a held key shall be re-accepted after DEBOUNCE_SCANS full sweeps and shall produce one KEY_VALID.

Configuration
REQ-025 Macro KEYPAD_GHOST_REJECT_EN selects multi-key handling.
  - Defined: when the accepted state has two or more keys, KEYS, STAR and HASH shall all be 0, with MULTI = 1.
  - Undefined: only the single highest-priority pressed key is reported. Priority is digits 0..9 ascending, then *, then #. MULTI still reflects the raw count.

Verification
REQ-026 SCAN_DIV=4, DEBOUNCE_SCANS=3. Hold 5 (row1/col1 low while col1 driven) from reset release. Required: KEYS=10'h020 and KEY_VALID=1 for one cycle, with KEY_CODE=5, by cycle 3 sweeps + 1 = 37 after the first capture. No further strobe while held.
REQ-027 Toggle key 2 every sweep for 10 sweeps. Required: KEYS stays 0 and KEY_VALID never asserts.
REQ-028 Hold 1 and 2 together with the macro defined. Required: KEYS=0, MULTI=1, no KEY_VALID. With the macro undefined: KEYS=10'h002, MULTI=1.
REQ-029 Press #, then release. Required: HASH=1 after acceptance, then HASH=0 three sweeps after release. No KEY_VALID at any point.
REQ-030 Hold 9 until accepted, then assert RESET for 2 cycles mid-sweep. Required: all outputs 0 and COL=3'b110 during reset. After release, KEYS=10'h200 with one KEY_VALID, KEY_CODE=9.
